// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// Cache-side line-fill controller. There is one instance per cache (I and D).
// On a miss it latches the line base address. It then requests the line from
// the arbiter one word at a time. Each returning fill word is written into the
// data array, and the tag array is written together with the last word.
// fsm_busy stays high for the whole fill so the pipeline stalls.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   miss_detected     cache lookup missed this cycle
//   miss_addr         byte address of the missing access
//   grant             arbiter accepts req_addr this cycle
//   fill_valid        one returning fill word is present
//   fill_data         the returning fill word (arrives in request order)
//   req, req_addr     request to the arbiter and byte address of the next word
//   fsm_busy          fill in progress; the pipeline must stall
//   write_data_array  write array_data at array_addr this cycle
//   write_tag_array   write tag/valid for the line that holds array_addr
//   array_addr        byte address of the word being written
//   array_data        data written to the data array (same as fill_data)
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              grant,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] array_addr,
  output logic [DATA_W-1:0] array_data
);

  // The counters need one extra bit so they can hold the value WORDS.
  // OFF_W is the number of byte-offset bits inside one line.
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int OFF_W = $clog2(2 * WORDS);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_recvd;
  logic [ADDR_W-1:0] r_base;
  logic              w_issue;
  logic              w_accept;

  // Next-state logic and all outputs. Every output is combinational, so a
  // fill word reaches the data array in the same cycle it arrives. Address
  // arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    w_next           = r_state;
    w_issue          = 1'b0;
    w_accept         = 1'b0;
    req              = 1'b0;
    req_addr         = '0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    array_addr       = '0;
    array_data       = '0;
    case (r_state)
      S_IDLE: begin
        if (miss_detected) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        fsm_busy = 1'b1;
        req      = (r_issued < CNT_W'(WORDS));
        req_addr = r_base + (ADDR_W'(r_issued) << 1);
        w_issue  = req && grant;
        // Fill words that arrive after the whole line has been counted are dropped.
        if (fill_valid && (r_recvd < CNT_W'(WORDS))) begin
          w_accept         = 1'b1;
          write_data_array = 1'b1;
          array_data       = fill_data;
          array_addr       = r_base + (ADDR_W'(r_recvd) << 1);
          if (r_recvd == CNT_W'(WORDS - 1)) begin
            write_tag_array = 1'b1;
            w_next          = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, line base and the two word counters. The issue and receive
  // counters advance independently of each other. A miss seen during a fill
  // is ignored, so the base address is latched only when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_issued <= '0;
      r_recvd  <= '0;
      r_base   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (miss_detected) begin
          r_base   <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_issued <= '0;
          r_recvd  <= '0;
        end
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + CNT_W'(1);
        end
        if (w_accept) begin
          r_recvd <= r_recvd + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_fsm
// Randomized bench for cache_fill_fsm.
// The driver starts line fills. For each fill it queues the expected request
// addresses, the expected array writes and the data of every fill word it
// presents. A monitor runs on the falling clock edge. It tracks busy and the
// words remaining with a line-level model, and checks every request and every
// array write against the queued expectations.
// ---------------------------------------------------------------------------
module tb_cache_fill_fsm;

  localparam int WORDS = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        tag;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        grant = 1'b0;
  logic        fill_valid = 1'b0;
  logic [15:0] fill_data = '0;
  logic        req;
  logic [15:0] req_addr;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] array_addr;
  logic [15:0] array_data;

  int total = 0;
  int bad = 0;

  logic [15:0] reqQ[$];
  wr_t         wrQ[$];
  logic [15:0] dataQ[$];

  bit expBusy = 1'b0;
  int left = 0;
  int busyRun = 0;
  int lastBusyLen = 0;

  cache_fill_fsm #(.WORDS(WORDS), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .miss_detected(miss_detected),
    .miss_addr(miss_addr),
    .grant(grant),
    .fill_valid(fill_valid),
    .fill_data(fill_data),
    .req(req),
    .req_addr(req_addr),
    .fsm_busy(fsm_busy),
    .write_data_array(write_data_array),
    .write_tag_array(write_tag_array),
    .array_addr(array_addr),
    .array_data(array_data)
  );

  always #5 clk = ~clk;

  // Compares one value against the bench's expectation and keeps the counts.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic miss, input logic [15:0] addr, input logic g,
                               input logic fv, input logic [15:0] data);
    miss_detected = miss;
    miss_addr     = addr;
    grant         = g;
    fill_valid    = fv;
    fill_data     = data;
  endtask

  task automatic checkAllZero(input string tagName);
    checkOutput({tagName, "_req"}, 32'(req), 32'd0);
    checkOutput({tagName, "_req_addr"}, 32'(req_addr), 32'd0);
    checkOutput({tagName, "_busy"}, 32'(fsm_busy), 32'd0);
    checkOutput({tagName, "_wr"}, 32'(write_data_array), 32'd0);
    checkOutput({tagName, "_tag"}, 32'(write_tag_array), 32'd0);
    checkOutput({tagName, "_array_addr"}, 32'(array_addr), 32'd0);
    checkOutput({tagName, "_array_data"}, 32'(array_data), 32'd0);
  endtask

  // The monitor compares what the DUT presents against a line-level model.
  // After a miss seen while idle, the DUT is busy for the whole line. Each
  // accepted fill word is written in order, and the tag goes with the last word.
  always @(negedge clk) begin
    bit expWr;
    wr_t w;
    if (!rst_n) begin
      expBusy = 1'b0;
      left    = 0;
      busyRun = 0;
    end else begin
      checkOutput("busy", 32'(fsm_busy), 32'(expBusy));
      checkOutput("req", 32'(req), 32'(expBusy && reqQ.size() > 0));
      if (req && grant) begin
        if (reqQ.size() == 0) checkOutput("req_extra", 32'd1, 32'd0);
        else checkOutput("req_addr", 32'(req_addr), 32'(reqQ.pop_front()));
      end else if (req && reqQ.size() > 0) begin
        checkOutput("req_addr_hold", 32'(req_addr), 32'(reqQ[0]));
      end
      expWr = expBusy && fill_valid && left > 0;
      checkOutput("wr_en", 32'(write_data_array), 32'(expWr));
      checkOutput("tag_en", 32'(write_tag_array), 32'(expWr && left == 1));
      if (write_data_array && expWr) begin
        if (wrQ.size() == 0 || dataQ.size() == 0) begin
          checkOutput("wr_extra", 32'd1, 32'd0);
        end else begin
          w = wrQ.pop_front();
          checkOutput("array_addr", 32'(array_addr), 32'(w.addr));
          checkOutput("array_data", 32'(array_data), 32'(dataQ.pop_front()));
        end
      end
      if (fsm_busy) busyRun++;
      else if (busyRun > 0) begin
        lastBusyLen = busyRun;
        busyRun = 0;
      end
      if (!expBusy) begin
        if (miss_detected) begin
          expBusy = 1'b1;
          left    = WORDS;
        end
      end else if (expWr) begin
        left--;
        if (left == 0) expBusy = 1'b0;
      end
    end
  end

  // Presents a miss for one cycle while idle and queues the whole expected line.
  task automatic startMiss(input logic [15:0] addr);
    logic [15:0] base;
    wr_t w;
    base = addr - (addr % 16'(2 * WORDS));
    for (int k = 0; k < WORDS; k++) begin
      reqQ.push_back(base + 16'(2 * k));
      w.addr = base + 16'(2 * k);
      w.tag  = (k == WORDS - 1);
      wrQ.push_back(w);
    end
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 16'h0);
    tick();
    miss_detected = 1'b0;
  endtask

  // Acts as the arbiter during one fill. grantPct and fvPct set how often grant
  // and fill_valid are offered. lat is the minimum grant-to-data latency. A
  // hold window can withhold grant, and missNoise toggles miss_detected at
  // random. abortAfter pulses rst_n once that many words have been received.
  // chainMiss raises the next miss in the same cycle as the last word.
  task automatic runFill(input int grantPct, input int fvPct, input int lat,
                         input int holdAfter, input int holdLen, input bit missNoise,
                         input int abortAfter, input bit chainMiss, input logic [15:0] chainAddr);
    int issued = 0;
    int recvd = 0;
    int holdCnt = 0;
    int grantTimes[$];
    bit done = 1'b0;
    bit g, fv;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (abortAfter >= 0 && recvd == abortAfter) begin
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        reqQ.delete();
        wrQ.delete();
        dataQ.delete();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        checkAllZero("rst_held");
        rst_n = 1'b1;
        return;
      end
      g = ($urandom_range(99) < grantPct);
      if (holdAfter >= 0 && issued == holdAfter && holdCnt < holdLen) begin
        g = 1'b0;
        holdCnt++;
      end
      fv = (grantTimes.size() > 0) && (cyc >= grantTimes[0] + lat) && ($urandom_range(99) < fvPct);
      applyStimulus(missNoise ? 1'($urandom_range(1)) : 1'b0, 16'($urandom), g, fv, 16'($urandom));
      if (fv) begin
        void'(grantTimes.pop_front());
        recvd++;
        dataQ.push_back(fill_data);
      end
      if (g && issued < WORDS) begin
        issued++;
        grantTimes.push_back(cyc);
      end
      if (fv && recvd == WORDS) begin
        done = 1'b1;
        if (chainMiss) begin
          miss_detected = 1'b1;
          miss_addr     = chainAddr;
        end
      end
      tick();
    end
    if (!done) checkOutput("fill_timeout", 32'd1, 32'd0);
    grant      = 1'b0;
    fill_valid = 1'b0;
    if (!chainMiss) miss_detected = 1'b0;
  endtask

  initial begin
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    #12;
    checkAllZero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: steady grants, data returns 4 cycles after each grant.
    startMiss(16'h1236);
    runFill(100, 100, 4, -1, 0, 1'b0, -1, 1'b0, 16'h0);
    tick();
    checkOutput("busy_len", 32'(lastBusyLen), 32'd12);

    // 2: grant withheld for 3 cycles once word 2 is pending.
    startMiss(16'h1236);
    runFill(100, 100, 4, 2, 3, 1'b0, -1, 1'b0, 16'h0);
    tick();

    // 3: stray fill words and grants while idle, then miss noise during a fill.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'($urandom));
      tick();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    startMiss(16'h5a5a);
    runFill(70, 70, 2, -1, 0, 1'b1, -1, 1'b0, 16'h0);
    tick();

    // 4: reset pulse after 5 words, then a fresh fill that starts at word 0.
    startMiss(16'h2222);
    runFill(100, 100, 2, -1, 0, 1'b0, 5, 1'b0, 16'h0);
    tick();
    startMiss(16'h2222);
    runFill(100, 100, 3, -1, 0, 1'b0, -1, 1'b0, 16'h0);
    tick();

    // 5: the top line of the address space.
    startMiss(16'hFFFF);
    runFill(100, 100, 4, -1, 0, 1'b0, -1, 1'b0, 16'h0);
    tick();

    // 6: back-to-back misses, with the second miss high at completion.
    startMiss(16'h0010);
    runFill(100, 100, 4, -1, 0, 1'b0, -1, 1'b1, 16'h0020);
    startMiss(16'h0020);
    runFill(100, 100, 4, -1, 0, 1'b0, -1, 1'b0, 16'h0);
    tick();

    // Random fills with mixed arbiter behaviour.
    for (int t = 0; t < 8; t++) begin
      startMiss(16'($urandom));
      runFill($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(6, 1),
              -1, 0, 1'($urandom_range(1)), -1, 1'b0, 16'h0);
      tick();
    end

    tick();
    checkOutput("reqQ_empty", 32'(reqQ.size()), 32'd0);
    checkOutput("wrQ_empty", 32'(wrQ.size()), 32'd0);
    checkOutput("dataQ_empty", 32'(dataQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
